// File: rtl/nsa_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
// Optional feature macro: OVERFLOW_FLAG_EN (see nibble_serial_adder.sv).
package nsa_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   function automatic int unsigned nsa_steps(input int unsigned width);
      return width / NIBBLE_W;
   endfunction

   // Step counter width; a single-step build still needs one bit.
   function automatic int unsigned nsa_idx_w(input int unsigned width);
      int unsigned n;
      n = nsa_steps(width);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// OVERFLOW_FLAG_EN adds the out_ovf signal.
interface nibble_serial_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_c;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_c;
`ifdef OVERFLOW_FLAG_EN
   logic             out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_c, out_ready,
      input  in_ready, out_valid, out_sum, out_c, out_ovf
   );
   modport slave (
      input  in_valid, in_a, in_b, in_c, out_ready,
      output in_ready, out_valid, out_sum, out_c, out_ovf
   );
`else
   modport master (
      output in_valid, in_a, in_b, in_c, out_ready,
      input  in_ready, out_valid, out_sum, out_c
   );
   modport slave (
      input  in_valid, in_a, in_b, in_c, out_ready,
      output in_ready, out_valid, out_sum, out_c
   );
`endif
endinterface

// File: rtl/adder4_slice.sv
// Combinational 4-bit adder slice: s/c_out = a + b + c_in.
module adder4_slice
   import nsa_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                c_in,
   output logic [NIBBLE_W-1:0] s,
   output logic                c_out
);

   always_comb begin
      {c_out, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, c_in};
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder driving one 4-bit slice a nibble per cycle, carry chained via carry_q.
// Define OVERFLOW_FLAG_EN to add the registered signed-overflow output out_ovf.
module nibble_serial_adder
   import nsa_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   nibble_serial_adder_if.slave bus
);

   localparam int unsigned N     = nsa_steps(WIDTH);
   localparam int unsigned IDX_W = nsa_idx_w(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
   end

   state_e                      state_q, state_d;
   logic [WIDTH-1:0]            a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic                        carry_q, carry_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [NIBBLE_W-1:0]         slice_s;
   logic                        slice_c;
   logic [WIDTH+NIBBLE_W-1:0]   sum_shift;

   adder4_slice u_slice (
      .a     (a_q[NIBBLE_W-1:0]),
      .b     (b_q[NIBBLE_W-1:0]),
      .c_in  (carry_q),
      .s     (slice_s),
      .c_out (slice_c)
   );

   // New nibble enters at the top so the LSB nibble ends up at the bottom.
   assign sum_shift = {slice_s, sum_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.in_valid)      state_d = StRun;
         StRun:   if (idx_q == LAST_IDX) state_d = StDone;
         StDone:  if (bus.out_ready)     state_d = StIdle;
         default:                        state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == StIdle);
      bus.out_valid = (state_q == StDone);
      bus.out_sum   = sum_q;
      bus.out_c     = carry_q;
   end

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               carry_d = bus.in_c;
               idx_d   = '0;
            end
         end
         StRun: begin
            a_d     = a_q >> NIBBLE_W;
            b_d     = b_q >> NIBBLE_W;
            sum_d   = sum_shift[WIDTH+NIBBLE_W-1:NIBBLE_W];
            carry_d = slice_c;
            idx_d   = idx_q + IDX_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
      end
   end

`ifdef OVERFLOW_FLAG_EN
   logic a_msb_q, b_msb_q, ovf_q, ovf_d;
   logic accept, last_step;

   assign accept    = (state_q == StIdle) && bus.in_valid;
   assign last_step = (state_q == StRun) && (idx_q == LAST_IDX);

   // The final slice output is the sum MSB, so overflow resolves on the last step.
   always_comb begin
      ovf_d = ovf_q;
      if (accept)         ovf_d = 1'b0;
      else if (last_step) ovf_d = (a_msb_q == b_msb_q) && (slice_s[NIBBLE_W-1] != a_msb_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (accept) begin
            a_msb_q <= bus.in_a[WIDTH-1];
            b_msb_q <= bus.in_b[WIDTH-1];
         end
         ovf_q <= ovf_d;
      end
   end

   assign bus.out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
// Overflow checks are compiled in when OVERFLOW_FLAG_EN is defined.
module tb_nibble_serial_adder;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   nibble_serial_adder_if #(.WIDTH(16)) bus ();

   nibble_serial_adder #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag, output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (lat >= 20) check({tag, "_timeout"}, 32'(lat), 32'd4);
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [15:0] es, input logic ec, input logic eo);
      int lat;
      @(negedge clk);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_c      = c;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      wait_valid(tag, lat);
      check({tag, "_latency"}, 32'(lat), 32'd4);
      check({tag, "_sum"}, 32'(bus.out_sum), 32'(es));
      check({tag, "_c"}, 32'(bus.out_c), 32'(ec));
`ifdef OVERFLOW_FLAG_EN
      check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(eo));
`else
      if (eo === 1'bx) $display("note: %s overflow expectation undefined", tag);
`endif
      @(posedge clk);
      #1;
      check({tag, "_valid_pulse"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_back_idle"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      logic [15:0] va [3];
      logic [15:0] vb [3];
      logic        vc [3];
      logic [15:0] vs [3];
      logic        vco [3];
      int acc_n, res_n, last_acc;

      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_c      = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      #12;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_sum", 32'(bus.out_sum), 32'd0);
      check("rst_out_c", 32'(bus.out_c), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic and full-ripple carries
      run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

      // Backpressure with a pending second request
      @(negedge clk);
      bus.in_a      = 16'h00FF;
      bus.in_b      = 16'h0001;
      bus.in_c      = 1'b0;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      wait_valid("bp", lat);
      @(negedge clk);
      bus.in_a     = 16'h0001;
      bus.in_b     = 16'h0001;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid_held", 32'(bus.out_valid), 32'd1);
         check("bp_sum_held", 32'(bus.out_sum), 32'h0100);
         check("bp_c_held", 32'(bus.out_c), 32'd0);
         check("bp_no_accept", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_handshake_idle", 32'(bus.in_ready), 32'd1);
      check("bp_handshake_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("bp_second_accepted", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b0;
      wait_valid("bp2", lat);
      check("bp2_latency", 32'(lat), 32'd4);
      check("bp2_sum", 32'(bus.out_sum), 32'h0002);
      check("bp2_c", 32'(bus.out_c), 32'd0);
      @(posedge clk);
      #1;

      // Asynchronous abort mid-run
      @(negedge clk);
      bus.in_a     = 16'hAAAA;
      bus.in_b     = 16'h5555;
      bus.in_c     = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      check("abort_out_sum", 32'(bus.out_sum), 32'd0);
      check("abort_out_c", 32'(bus.out_c), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_abort", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0);

      // Back-to-back with in_valid held high
      va[0] = 16'h0101; vb[0] = 16'h0202; vc[0] = 1'b0; vs[0] = 16'h0303; vco[0] = 1'b0;
      va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 1'b1; vs[1] = 16'h0001; vco[1] = 1'b1;
      va[2] = 16'h0FF0; vb[2] = 16'h0010; vc[2] = 1'b0; vs[2] = 16'h1000; vco[2] = 1'b0;
      acc_n    = 0;
      res_n    = 0;
      last_acc = 0;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (bus.out_valid && res_n < 3) begin
            check("b2b_sum", 32'(bus.out_sum), 32'(vs[res_n]));
            check("b2b_c", 32'(bus.out_c), 32'(vco[res_n]));
            res_n++;
         end
         if (bus.in_ready) begin
            if (acc_n < 3) begin
               if (acc_n > 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd6);
               last_acc     = cyc;
               bus.in_a     = va[acc_n];
               bus.in_b     = vb[acc_n];
               bus.in_c     = vc[acc_n];
               bus.in_valid = 1'b1;
               acc_n++;
            end else begin
               bus.in_valid = 1'b0;
            end
         end
      end
      bus.in_valid = 1'b0;
      check("b2b_accepts", 32'(acc_n), 32'd3);
      check("b2b_results", 32'(res_n), 32'd3);

`ifdef OVERFLOW_FLAG_EN
      run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      run_op("ovf_none", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
